// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared widths, default queue depth and queue-entry record for the writeback arbiter
package mips_wb_pkg;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int NREG       = 1 << ADDR_W;
    localparam int QDEPTH_DEF = 4;
    // Wide enough to hold a count of 16 for the largest supported depth
    localparam int CNT_W      = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/mips_wb_arbiter_if.sv
// mips_wb_arbiter_if: writeback arbiter bus bundle
//   master: pipeline/mul-div/issue requests in, register-file write and status out (testbench side)
//   slave : the arbiter's view of the same signals
interface mips_wb_arbiter_if;
    import mips_wb_pkg::*;
    logic              PipeWE;
    logic [ADDR_W-1:0] PipeWAdr;
    logic [DATA_W-1:0] PipeData;
    logic              MdValid;
    logic [ADDR_W-1:0] MdAdr;
    logic [DATA_W-1:0] MdData;
    logic              MdReady;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueAdr;
    logic              WE;
    logic [ADDR_W-1:0] WD;
    logic [DATA_W-1:0] Din;
    logic [NREG-1:0]   Pending;
    logic [CNT_W-1:0]  QCount;

    modport master (
        output PipeWE, PipeWAdr, PipeData, MdValid, MdAdr, MdData, IssueValid, IssueAdr,
        input  MdReady, WE, WD, Din, Pending, QCount
    );

    modport slave (
        input  PipeWE, PipeWAdr, PipeData, MdValid, MdAdr, MdData, IssueValid, IssueAdr,
        output MdReady, WE, WD, Din, Pending, QCount
    );
endinterface

// File: rtl/mips_wb_fifo.sv
// mips_wb_fifo: synchronous count-based FIFO holding queued multiply/divide writebacks
//   clk, rst       : clock, synchronous active-high reset
//   i_push, i_data : enqueue request and entry (ignored when full)
//   i_pop          : dequeue request (ignored when empty)
//   o_head         : entry at the read pointer
//   o_count        : occupancy
module mips_wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  wb_entry_t        i_data,
    input  logic             i_pop,
    output wb_entry_t        o_head,
    output logic [CNT_W-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != FULL);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + PW'(1) : r_wr;
            r_rd    <= w_pop ? r_rd + PW'(1) : r_rd;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/mips_wb_arbiter.sv
// mips_wb_arbiter: merges pipeline and queued multiply/divide writebacks onto one register-file write port
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : slave modport; pipeline/Md/issue requests in, WE/WD/Din, MdReady, Pending, QCount out
module mips_wb_arbiter
    import mips_wb_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    mips_wb_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);
    localparam logic [NREG-1:0]  ONE  = NREG'(1);

    logic              w_pipe;
    logic              w_pop;
    logic              w_push;
    wb_entry_t         w_md;
    wb_entry_t         w_head;
    logic [CNT_W-1:0]  w_count;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic              r_we;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_din;
    logic [NREG-1:0]   r_pending;

    // Writes to $0 are dropped, so they neither take the port nor block a pop
    assign w_pipe = bus.PipeWE && (bus.PipeWAdr != '0);
    assign w_pop  = !w_pipe && (w_count != '0);
    // $0 results are acknowledged but never stored
    assign w_push = bus.MdValid && bus.MdReady && (bus.MdAdr != '0);
    assign w_md   = '{adr: bus.MdAdr, data: bus.MdData};
    assign w_set  = bus.IssueValid ? ONE << bus.IssueAdr : '0;
    assign w_clr  = w_pop ? ONE << w_head.adr : '0;

    // Readiness comes from the registered count so a full queue refuses even while popping
    assign bus.MdReady = w_count < FULL;
    assign bus.QCount  = w_count;
    assign bus.WE      = r_we;
    assign bus.WD      = r_wd;
    assign bus.Din     = r_din;
    assign bus.Pending = r_pending;

    mips_wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .i_push  (w_push),
        .i_data  (w_md),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_we      <= 1'b0;
            r_wd      <= '0;
            r_din     <= '0;
            r_pending <= '0;
        end else begin
            r_we  <= w_pipe || w_pop;
            r_wd  <= w_pipe ? bus.PipeWAdr : (w_pop ? w_head.adr : r_wd);
            r_din <= w_pipe ? bus.PipeData : (w_pop ? w_head.data : r_din);
            // Set after clear so a re-issue to the draining register stays pending; $0 never pends
            r_pending <= ((r_pending & ~w_clr) | w_set) & ~ONE;
        end
    end
endmodule
